// File: rtl/sum_operand_recover_if.sv
// Request/response bundle for sum_operand_recover.
// Upstream (master) presents sum_i/add1_i with in_valid_i and takes the
// result with out_ready_i. The recover block (slave) returns in_ready_o,
// out_valid_o and diff_o. ovf_o is present only when SUB_OVF_FLAG_EN is
// defined.
interface sum_operand_recover_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH:0]   sum_i;
  logic [WIDTH-1:0] add1_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] diff_o;
`ifdef SUB_OVF_FLAG_EN
  logic             ovf_o;
`endif

  modport master (
    output in_valid_i, sum_i, add1_i, out_ready_i,
    input  in_ready_o, out_valid_o, diff_o
`ifdef SUB_OVF_FLAG_EN
    , input ovf_o
`endif
  );

  modport slave (
    input  in_valid_i, sum_i, add1_i, out_ready_i,
    output in_ready_o, out_valid_o, diff_o
`ifdef SUB_OVF_FLAG_EN
    , output ovf_o
`endif
  );
endinterface

// File: rtl/sum_operand_recover.sv
// sum_operand_recover: digit-serial subtractor recovering the second addend
// of a WIDTH-bit adder, diff = sum[WIDTH-1:0] - add1 mod 2^WIDTH, processing
// DIGIT_W bits per cycle (N = WIDTH/DIGIT_W RUN cycles).
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - sum_operand_recover_if.slave: in_valid_i/in_ready_o request
//            handshake with sum_i (WIDTH+1) and add1_i (WIDTH);
//            out_valid_o/out_ready_i response handshake with diff_o (WIDTH)
//            and, when SUB_OVF_FLAG_EN is defined, ovf_o.
// Optional feature macro: SUB_OVF_FLAG_EN (adds ovf_o and the sum msb register).
// The interface WIDTH parameter must equal this module's WIDTH.
module sum_operand_recover #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIGIT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  sum_operand_recover_if.slave     bus
);

  localparam int unsigned N     = (DIGIT_W == 0) ? 1 : WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  // Digit width must tile the operand exactly.
  generate
    if (DIGIT_W == 0) begin : g_bad_digit_zero
      $error("sum_operand_recover: DIGIT_W must be non-zero");
    end else if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_div
      $error("sum_operand_recover: DIGIT_W must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic [WIDTH-1:0]   r_sum_sh,    w_sum_sh_nxt;
  logic [WIDTH-1:0]   r_add_sh,    w_add_sh_nxt;
  logic [WIDTH-1:0]   r_dsh,       w_dsh_nxt;
  logic [WIDTH-1:0]   r_diff,      w_diff_nxt;
  logic               r_borrow,    w_borrow_nxt;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic               r_in_ready,  w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
`ifdef SUB_OVF_FLAG_EN
  logic               r_msb,       w_msb_nxt;
  logic               r_ovf,       w_ovf_nxt;
`else
  logic               w_unused_msb;
  assign w_unused_msb = bus.sum_i[WIDTH];
`endif

  // One digit of the borrow chain: {borrow_out, digit} at DIGIT_W+1 bits.
  logic [DIGIT_W:0]          w_sub;
  logic [WIDTH+DIGIT_W-1:0]  w_dcat;
  logic [WIDTH+DIGIT_W-1:0]  w_scat;
  logic [WIDTH+DIGIT_W-1:0]  w_acat;
  logic                      w_last;

  assign w_sub  = {1'b0, r_sum_sh[DIGIT_W-1:0]}
                - {1'b0, r_add_sh[DIGIT_W-1:0]}
                - {{DIGIT_W{1'b0}}, r_borrow};
  // Concatenations give right-shift-by-DIGIT_W that stays legal when DIGIT_W == WIDTH.
  assign w_dcat = {w_sub[DIGIT_W-1:0], r_dsh};
  assign w_scat = {{DIGIT_W{1'b0}}, r_sum_sh};
  assign w_acat = {{DIGIT_W{1'b0}}, r_add_sh};
  assign w_last = (r_cnt == CNT_W'(N - 1));

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_sum_sh_nxt    = r_sum_sh;
    w_add_sh_nxt    = r_add_sh;
    w_dsh_nxt       = r_dsh;
    w_diff_nxt      = r_diff;
    w_borrow_nxt    = r_borrow;
    w_cnt_nxt       = r_cnt;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
`ifdef SUB_OVF_FLAG_EN
    w_msb_nxt       = r_msb;
    w_ovf_nxt       = r_ovf;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid_i && r_in_ready) begin
          w_sum_sh_nxt   = bus.sum_i[WIDTH-1:0];
          w_add_sh_nxt   = bus.add1_i;
          w_borrow_nxt   = 1'b0;
          w_cnt_nxt      = '0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = S_RUN;
`ifdef SUB_OVF_FLAG_EN
          w_msb_nxt      = bus.sum_i[WIDTH];
`endif
        end
      end
      S_RUN: begin
        w_sum_sh_nxt = w_scat[WIDTH+DIGIT_W-1:DIGIT_W];
        w_add_sh_nxt = w_acat[WIDTH+DIGIT_W-1:DIGIT_W];
        w_dsh_nxt    = w_dcat[WIDTH+DIGIT_W-1:DIGIT_W];
        w_borrow_nxt = w_sub[DIGIT_W];
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (w_last) begin
          // diff_o only changes here, with the completed word.
          w_diff_nxt      = w_dcat[WIDTH+DIGIT_W-1:DIGIT_W];
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_DONE;
`ifdef SUB_OVF_FLAG_EN
          // Sum msb against final borrow: mismatch means no WIDTH-bit addend fits.
          w_ovf_nxt       = r_msb ^ w_sub[DIGIT_W];
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sum_sh    <= '0;
      r_add_sh    <= '0;
      r_dsh       <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      r_msb       <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sum_sh    <= w_sum_sh_nxt;
      r_add_sh    <= w_add_sh_nxt;
      r_dsh       <= w_dsh_nxt;
      r_diff      <= w_diff_nxt;
      r_borrow    <= w_borrow_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifdef SUB_OVF_FLAG_EN
      r_msb       <= w_msb_nxt;
      r_ovf       <= w_ovf_nxt;
`endif
    end
  end

  assign bus.in_ready_o  = r_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.diff_o      = r_diff;
`ifdef SUB_OVF_FLAG_EN
  assign bus.ovf_o       = r_ovf;
`endif

endmodule

// File: doc/sum_operand_recover.md
Name: sum_operand_recover

Overview:
- Digit-serial inverse of the 32-bit adder datapath.
- Takes a WIDTH+1-bit sum and one WIDTH-bit addend; computes the other addend as sum - add1 over multiple cycles.
- Flags sums that no WIDTH-bit second addend could have produced.
- Sits downstream of the adder in the obfuscation test harness to recover and cross-check operands.

Parameters:
- WIDTH, 32, operand width; result_o of the adder is WIDTH+1 bits.
- DIGIT_W, 8, bits processed per cycle. Must divide WIDTH; elaboration error otherwise.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  block can accept a request.
- sum_i  input  WIDTH+1  adder result to invert.
- add1_i  input  WIDTH  known addend.
- out_valid_o  output  1  diff_o (and ovf_o) valid.
- out_ready_i  input  1  consumer accepts the result.
- diff_o  output  WIDTH  recovered addend, sum_i[WIDTH-1:0] - add1_i mod 2^WIDTH.
- ovf_o  output  1  present only with SUB_OVF_FLAG_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready_o=1, out_valid_o=0, diff_o=0, ovf_o=0; borrow and digit counter cleared.
- Reset mid-RUN or mid-DONE aborts the operation. The pending result is discarded and out_valid_o drops immediately.
- Let N = WIDTH/DIGIT_W. FSM states are IDLE, RUN, DONE.
- IDLE: in_ready_o=1.
  - Accept on in_valid_i & in_ready_o: latch sum_i[WIDTH-1:0] and add1_i into shift regs, sum_i[WIDTH] into msb reg.
  - Clear borrow and counter; go to RUN.
- RUN (N cycles): in_ready_o=0.
  - Each cycle: {b, d} = s[DIGIT_W-1:0] - a[DIGIT_W-1:0] - borrow, at DIGIT_W+1 bits.
  - Shift d into diff shift reg from the top; shift s and a right by DIGIT_W; borrow<=b; counter++.
  - After the Nth digit go to DONE.
- DONE: out_valid_o=1; diff_o holds the full result and is stable while out_valid_o=1 and out_ready_i=0.
  - On out_ready_i: out_valid_o<=0 next cycle; go to IDLE.
  - No same-cycle bypass: in_ready_o=0 in DONE.
- Latency: acceptance edge to out_valid_o high is N+1 edges (5 for defaults). Throughput is one request per N+2 cycles when the consumer is always ready.
- diff_o is registered. It holds its last value in IDLE and is updated only at the final RUN digit.
- in_valid_i while not ready is ignored; the upstream holds it.
- Arithmetic is unsigned modular; final borrow out of bit WIDTH-1 is kept.
- Boundaries, all wrap mod 2^WIDTH with no stall:
  - add1=0: diff=sum[WIDTH-1:0].
  - sum=add1: diff=0.
  - all-ones operands: diff wraps correctly.

Optional Feature:
- Macro SUB_OVF_FLAG_EN.
- Defined: port ovf_o exists.
  - Registered at the DONE transition: ovf_o = msb_reg XOR final_borrow.
  - Set when sum_i < add1_i, or when sum_i - add1_i >= 2^WIDTH.
  - Same valid timing as diff_o; reset value 0.
- Undefined: no ovf_o port and no msb register; sum_i[WIDTH] is ignored. Everything else is identical.

Test Plan:
- Reset with in_valid_i=0 -> in_ready_o=1, out_valid_o=0, diff_o=0; assert rst_i during RUN -> out_valid_o=0, in_ready_o=1 after release.
- sum_i=0x0_0000_0003, add1_i=0x0000_0001 -> out_valid_o high 5 edges after accept, diff_o=0x0000_0002, ovf_o=0.
- sum_i=0x1_FFFF_FFFE, add1_i=0xFFFF_FFFF -> diff_o=0xFFFF_FFFF, ovf_o=0 (borrow chain across all 4 digits).
- sum_i=0x0_0000_0000, add1_i=0x0000_0001 -> diff_o=0xFFFF_FFFF, ovf_o=1; sum_i=0x1_0000_0000, add1_i=0 -> diff_o=0, ovf_o=1.
- Hold out_ready_i=0 for 10 cycles in DONE with in_valid_i=1 -> diff_o stable, in_ready_o=0, no second accept; release -> next request accepted next IDLE cycle.
- 1000 random (a,b) pairs with sum_i=a+b (33-bit) and add1_i=a -> diff_o=b and ovf_o=0 every time; repeat with DIGIT_W=4 and DIGIT_W=32 (latency 9 and 2).
